// File: rtl/bpu_btb_if.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb_if
// Brief    : Fetch-lookup and execute-resolve signal bundle for bpu_btb.
// Revision : 1.0 - initial release
// ============================================================================
interface bpu_btb_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_br_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    // Pipeline side drives requests and resolutions
    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_pc, ex_is_branch, ex_br_taken, ex_br_target,
        output ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    // Predictor side
    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_pc, ex_is_branch, ex_br_taken, ex_br_target,
        input  ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb
// Brief    : Direct-mapped BTB with 2-bit counters, plus execute-stage
//            mispredict detection and registered redirect.
//            Optional macro BPU_PERF_CNT_EN adds branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    bpu_btb_if.slave         bus
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_br_cnt,
    output logic [31:0]      perf_mis_cnt
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [XLEN-1:0] c_inc4     = XLEN'(4);
    localparam logic [1:0]      c_ctr_rst  = 2'b01;
    localparam logic [1:0]      c_ctr_new  = 2'b10;
    localparam logic [1:0]      c_ctr_max  = 2'b11;
    localparam logic [1:0]      c_ctr_min  = 2'b00;

    logic             r_valid  [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];

    logic             r_mispredict;
    logic [XLEN-1:0]  r_redirect_pc;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_pred_taken;

    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_taken;
    logic             w_mis;
    logic [1:0]       w_ctr_next;
    logic [XLEN-1:0]  w_redirect_next;
    logic             w_unused;

    // ---------------- Fetch-side lookup ----------------
    assign w_if_idx     = bus.if_pc[IDX_W+1:2];
    assign w_if_tag     = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_if_hit     = bus.if_valid & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit & r_ctr[w_if_idx][1];

    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_taken ? r_target[w_if_idx] : (bus.if_pc + c_inc4);

    // ---------------- Execute-side resolve ----------------
    assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
    assign w_ex_tag = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

    // A non-branch never counts as taken, so any taken prediction on it is an alias
    assign w_taken = bus.ex_is_branch & bus.ex_br_taken;
    assign w_mis   = bus.ex_valid &
                     ((w_taken != bus.ex_pred_taken) |
                      (w_taken & (bus.ex_br_target != bus.ex_pred_target)));

    assign w_redirect_next = w_taken ? bus.ex_br_target : (bus.ex_pc + c_inc4);

    always_comb begin
        w_ctr_next = r_ctr[w_ex_idx];
        if (w_taken) begin
            if (r_ctr[w_ex_idx] != c_ctr_max) w_ctr_next = r_ctr[w_ex_idx] + 2'd1;
        end else begin
            if (r_ctr[w_ex_idx] != c_ctr_min) w_ctr_next = r_ctr[w_ex_idx] - 2'd1;
        end
    end

    // Valid bits and counters carry reset state; tags/targets do not need it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= c_ctr_rst;
            end
        end else if (bus.ex_valid) begin
            if (bus.ex_is_branch) begin
                if (w_ex_hit) begin
                    r_ctr[w_ex_idx] <= w_ctr_next;
                end else if (bus.ex_br_taken) begin
                    r_valid[w_ex_idx] <= 1'b1;
                    r_ctr[w_ex_idx]   <= c_ctr_new;
                end
            end else if (w_ex_hit) begin
                r_valid[w_ex_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.ex_valid & w_taken) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= bus.ex_br_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_mispredict <= w_mis;
            if (w_mis) r_redirect_pc <= w_redirect_next;
        end
    end

    assign bus.mispredict  = r_mispredict;
    assign bus.redirect_pc = r_redirect_pc;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_perf_br_cnt;
    logic [31:0] r_perf_mis_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_br_cnt  <= '0;
            r_perf_mis_cnt <= '0;
        end else begin
            if (bus.ex_valid & bus.ex_is_branch) r_perf_br_cnt <= r_perf_br_cnt + 32'd1;
            if (w_mis) r_perf_mis_cnt <= r_perf_mis_cnt + 32'd1;
        end
    end

    assign perf_br_cnt  = r_perf_br_cnt;
    assign perf_mis_cnt = r_perf_mis_cnt;
`endif

    // Low and high PC bits take no part in indexing
    assign w_unused = ^{bus.if_pc, bus.ex_pc};
endmodule
`default_nettype wire
